jk_seq_driver: RTL and testbench
================================

# jk_seq_driver

Sequencer that drives an external bank of JK flip-flops to a requested target state and checks the result. Each accepted target vector is translated through the JK excitation table against the live Q feedback into per-bit J/K commands. The bank is then allowed one edge to update, and the resulting Q is compared against the target. The block sits between a pattern source (valid/ready) and a `JK_flip_flop` bank. It reports completion, mismatch and a saturating error count.

## Interface

Parameters:
- `WIDTH`, default 4, is the number of JK flip-flops in the driven bank.
- `USE_TOGGLE`, default 0.
  - 0: state changes use set (J=1,K=0) or reset (J=0,K=1).
  - 1: state changes use toggle (J=1,K=1).
- `ERR_W`, default 8, is the width of the error counter.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `tgt_valid` input, 1 bit: a target vector is offered.
- `tgt_ready` output, 1 bit: the block can accept a target.
- `tgt_data` input, `WIDTH` bits: the target Q vector.
- `q_fb` input, `WIDTH` bits: Q outputs of the driven flip-flop bank.
- `j` output, `WIDTH` bits: J inputs to the bank (registered).
- `k` output, `WIDTH` bits: K inputs to the bank (registered).
- `busy` output, 1 bit: a sequence is in progress (DRIVE or CHECK).
- `done` output, 1 bit: one-cycle pulse when a sequence completes.
- `mismatch` output, 1 bit: one-cycle pulse, qualified by `done`, meaning the final Q differed from the target.
- `err_clr` input, 1 bit: synchronous clear of `err_count`.
- `err_count` output, `ERR_W` bits: number of mismatches, saturating at all-ones.

## Operation

- **FSM states:** IDLE → DRIVE → CHECK → IDLE.
- **IDLE**
  - `tgt_ready`=1, `j`=`k`=0.
  - On `tgt_valid` && `tgt_ready`: latch `tgt_data` into `tgt_q`, register `j`/`k` from the excitation of (`q_fb`, `tgt_data`) sampled on that edge, then go to DRIVE.
- **DRIVE**
  - `j`/`k` hold the excitation for the whole cycle.
  - The bank samples them on the edge that ends DRIVE.
  - That edge loads `j`=`k`=0 (hold) and moves the FSM to CHECK.
- **CHECK**
  - `j`=`k`=0.
  - On the ending edge, compare `q_fb` with `tgt_q`.
  - Register `done`=1 and `mismatch`=(`q_fb`!=`tgt_q`), then go to IDLE.
- **Excitation, per bit, with q=`q_fb[i]` and t=target bit:**
  - q==t: J=0, K=0 (hold).
  - q=0, t=1: J=1, K=0 if `USE_TOGGLE`=0; J=1, K=1 if `USE_TOGGLE`=1.
  - q=1, t=0: J=0, K=1 if `USE_TOGGLE`=0; J=1, K=1 if `USE_TOGGLE`=1.
  - J=K=1 never appears when `USE_TOGGLE`=0.
- **Handshake rules**
  - `tgt_valid` and `tgt_data` are ignored while `tgt_ready`=0.
  - `tgt_data` need not stay stable after acceptance.
- **`err_count`**
  - Increments by 1 on each mismatch and stops at 2^`ERR_W`-1.
  - `err_clr` sets it to 0 on the next edge.
  - If `err_clr` coincides with a mismatch, the clear wins and the result is 0.
- **Reset values**
  - FSM=IDLE, `j`=`k`=0, `done`=`mismatch`=0, `busy`=0, `err_count`=0, `tgt_q`=0.
  - `tgt_ready`=1 in the first cycle after reset.
- **Reset mid-sequence:** abandons the sequence. No `done` or `mismatch` pulse, `err_count` is cleared, and `j`/`k` are 0 from the next cycle.

## Timing

- Accept on edge N:
  - `j`/`k` are valid during cycle N→N+1 (DRIVE).
  - The bank updates at edge N+1.
  - The comparison happens at edge N+2.
  - `done` (and `mismatch`) are high during cycle N+2→N+3.
- Pipelining:
  - `tgt_ready` is high again in the `done` cycle, so a new target may be accepted at edge N+3.
  - Sustained throughput is 1 target per 3 cycles.
- `busy`=1 exactly during DRIVE and CHECK.
- `done` and `mismatch` last exactly one cycle and are never asserted outside the post-CHECK cycle.
- `q_fb` is sampled only at the accept edge and the CHECK-ending edge; its value in other cycles is don't-care.

## Test plan

- **Reset:** hold `reset`=1 for 2 cycles with random `tgt_valid` and `tgt_data`.
  - → `j`=`k`=0000, `done`=`mismatch`=`busy`=0, `err_count`=0.
  - → `tgt_ready`=1 after release.
- **Set/reset mapping:** `WIDTH`=4, `USE_TOGGLE`=0, with a real `JK_flip_flop` bank at Q=0000.
  - Target 1010 → `j`=1010, `k`=0000 in DRIVE; Q=1010; `done` pulse at N+2 with `mismatch`=0.
  - Next target 0101 → `j`=0101, `k`=1010.
- **Toggle mapping:** `USE_TOGGLE`=1, Q=1010.
  - Target 0101 → `j`=`k`=1111 in DRIVE; Q=0101; `mismatch`=0.
  - Target 0101 again → `j`=`k`=0000.
- **Fault detection and saturation:** bank bit 0 stuck at 0.
  - Target 0001 → `mismatch`=1 with `done`; `err_count`=1.
  - Repeat 300 times with `ERR_W`=8 → `err_count`=255.
  - Assert `err_clr` together with a mismatch → `err_count`=0.
- **Reset mid-operation:** assert `reset` during DRIVE.
  - → The next cycle is IDLE with `j`=`k`=0, `busy`=0.
  - → No `done` pulse follows.
- **Handshake:** hold `tgt_valid`=1 continuously, changing `tgt_data` every cycle.
  - → Targets are accepted only on edges where `tgt_ready`=1: back-to-back acceptance in the `done` cycle, one acceptance per 3 cycles.
  - → `tgt_data` presented during DRIVE or CHECK never appears in `j`/`k`.

Source files
------------

// File: rtl/jk_seq_driver.sv
// Drives an external JK flip-flop bank to a requested target state through the JK
// excitation table, lets the bank take one edge, then checks the resulting Q.
module jk_seq_driver #(
  parameter int WIDTH      = 4,
  parameter bit USE_TOGGLE = 1'b0,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);

  // Handshake: a target transfers on a rising edge where tgt_valid && tgt_ready;
  // tgt_ready is high only in IDLE, and tgt_data is captured on that edge only.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic             accept;
  logic             check_end;
  logic             check_bad;

  // Bits that must go 0->1 and 1->0 to reach the target from the live Q.
  assign rise = ~q_fb & tgt_data;
  assign fall = q_fb & ~tgt_data;

  always_comb begin
    exc_j = rise;
    exc_k = fall;
    if (USE_TOGGLE) begin
      exc_j = rise | fall;
      exc_k = rise | fall;
    end
  end

  always_comb begin
    state_nxt = state;
    j_nxt     = '0;
    k_nxt     = '0;
    tgt_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    check_end = 1'b0;
    case (state)
      IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          accept    = 1'b1;
          j_nxt     = exc_j;
          k_nxt     = exc_k;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        check_end = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign check_bad = check_end && (q_fb != tgt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      j         <= '0;
      k         <= '0;
      tgt_q     <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      state    <= state_nxt;
      j        <= j_nxt;
      k        <= k_nxt;
      done     <= check_end;
      mismatch <= check_bad;
      if (accept) begin
        tgt_q <= tgt_data;
      end
      // Clear takes priority over a coincident mismatch; the count saturates.
      if (err_clr) begin
        err_count <= '0;
      end else if (check_bad && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: two instances (set/reset and toggle mapping), each
// driving a behavioural JK bank with an optional stuck-at-0 fault mask.
module tb_jk_seq_driver;

  logic       clk;
  logic       reset;
  logic       tgt_valid [2];
  logic       tgt_ready [2];
  logic [3:0] tgt_data  [2];
  logic [3:0] q_fb      [2];
  logic [3:0] j         [2];
  logic [3:0] k         [2];
  logic       busy      [2];
  logic       done      [2];
  logic       mismatch  [2];
  logic       err_clr   [2];
  logic [7:0] err_count [2];

  logic [3:0] bank_q    [2];
  logic [3:0] stuck     [2];
  logic [3:0] bank_init [2];
  logic       bank_ld;

  logic [7:0] exp_q  [$];
  logic       mm_q   [$];
  int         exp_err [2];
  int         n_vec;
  int         n_bad;

  typedef struct {
    int         d;
    logic [3:0] stk;
    logic [3:0] tgt;
    logic [3:0] ej;
    logic [3:0] ek;
    logic       em;
  } vec_t;

  vec_t tbl [10];

  jk_seq_driver #(.WIDTH(4), .USE_TOGGLE(1'b0), .ERR_W(8)) u_set (
    .clk(clk), .reset(reset),
    .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]), .tgt_data(tgt_data[0]),
    .q_fb(q_fb[0]), .j(j[0]), .k(k[0]), .busy(busy[0]), .done(done[0]),
    .mismatch(mismatch[0]), .err_clr(err_clr[0]), .err_count(err_count[0])
  );

  jk_seq_driver #(.WIDTH(4), .USE_TOGGLE(1'b1), .ERR_W(8)) u_tog (
    .clk(clk), .reset(reset),
    .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]), .tgt_data(tgt_data[1]),
    .q_fb(q_fb[1]), .j(j[1]), .k(k[1]), .busy(busy[1]), .done(done[1]),
    .mismatch(mismatch[1]), .err_clr(err_clr[1]), .err_count(err_count[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  function automatic logic [3:0] bank_next(input logic [3:0] q, input logic [3:0] jj,
                                           input logic [3:0] kk);
    logic [3:0] n;
    n = q;
    for (int i = 0; i < 4; i++) begin
      case ({jj[i], kk[i]})
        2'b10:   n[i] = 1'b1;
        2'b01:   n[i] = 1'b0;
        2'b11:   n[i] = ~q[i];
        default: n[i] = q[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (bank_ld) bank_q[d] <= bank_init[d];
      else         bank_q[d] <= bank_next(bank_q[d], j[d], k[d]) & ~stuck[d];
    end
  end

  assign q_fb[0] = bank_q[0];
  assign q_fb[1] = bank_q[1];

  // Reference excitation: {j, k} for reaching t from q.
  function automatic logic [7:0] excite(input logic [3:0] q, input logic [3:0] t, input bit tog);
    logic [3:0] jj;
    logic [3:0] kk;
    jj = 4'b0;
    kk = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (q[i] != t[i]) begin
        if (tog) begin
          jj[i] = 1'b1;
          kk[i] = 1'b1;
        end else if (t[i]) begin
          jj[i] = 1'b1;
        end else begin
          kk[i] = 1'b1;
        end
      end
    end
    return {jj, kk};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver: one full accept/drive/check sequence, starting and ending on a negedge
  task automatic run_seq(input int d, input logic [3:0] tgt, input logic [3:0] ej,
                         input logic [3:0] ek, input logic em, input bit clr);
    logic [7:0] e;
    logic       m;
    exp_q.push_back({ej, ek});
    mm_q.push_back(em);
    chk("ready_idle", 32'(tgt_ready[d]), 32'(1));
    tgt_valid[d] = 1'b1;
    tgt_data[d]  = tgt;
    @(negedge clk);
    tgt_valid[d] = 1'b0;
    tgt_data[d]  = 4'($urandom_range(0, 15));
    e = exp_q.pop_front();
    chk("busy_drive", 32'(busy[d]), 32'(1));
    chk("ready_drive", 32'(tgt_ready[d]), 32'(0));
    chk("jk_drive", 32'({j[d], k[d]}), 32'(e));
    @(negedge clk);
    err_clr[d] = clr;
    chk("busy_check", 32'(busy[d]), 32'(1));
    chk("jk_check", 32'({j[d], k[d]}), 32'(0));
    chk("done_early", 32'(done[d]), 32'(0));
    @(negedge clk);
    err_clr[d] = 1'b0;
    m = mm_q.pop_front();
    chk("done", 32'(done[d]), 32'(1));
    chk("mismatch", 32'(mismatch[d]), 32'(m));
    chk("busy_done", 32'(busy[d]), 32'(0));
    if (clr) exp_err[d] = 0;
    else if (m && exp_err[d] != 255) exp_err[d]++;
    chk("err_count", 32'(err_count[d]), 32'(exp_err[d]));
  endtask

  initial begin
    logic [7:0] e;
    logic       em;
    int         ph;
    bit         done_exp;

    n_vec = 0;
    n_bad = 0;
    exp_err[0] = 0;
    exp_err[1] = 0;
    for (int d = 0; d < 2; d++) begin
      tgt_valid[d] = 1'b0;
      tgt_data[d]  = 4'b0;
      err_clr[d]   = 1'b0;
      stuck[d]     = 4'b0;
    end
    bank_init[0] = 4'b0000;
    bank_init[1] = 4'b1010;
    bank_ld = 1'b1;

    //            d  stuck   tgt      j        k        mm
    tbl[0] = '{0, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 1'b0};
    tbl[1] = '{0, 4'b0000, 4'b0101, 4'b0101, 4'b1010, 1'b0};
    tbl[2] = '{0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[3] = '{0, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 1'b0};
    tbl[4] = '{0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[5] = '{0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1};
    tbl[6] = '{1, 4'b0000, 4'b0101, 4'b1111, 4'b1111, 1'b0};
    tbl[7] = '{1, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[8] = '{1, 4'b0000, 4'b0110, 4'b0011, 4'b0011, 1'b0};
    tbl[9] = '{1, 4'b0000, 4'b1001, 4'b1111, 4'b1111, 1'b0};

    // reset with random handshake activity
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        tgt_valid[d] = 1'($urandom_range(0, 1));
        tgt_data[d]  = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      bank_ld = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk("rst_jk", 32'({j[d], k[d]}), 32'(0));
        chk("rst_done", 32'({done[d], mismatch[d]}), 32'(0));
        chk("rst_busy", 32'(busy[d]), 32'(0));
        chk("rst_err", 32'(err_count[d]), 32'(0));
      end
    end
    reset = 1'b0;
    tgt_valid[0] = 1'b0;
    tgt_valid[1] = 1'b0;
    @(negedge clk);
    chk("rst_ready0", 32'(tgt_ready[0]), 32'(1));
    chk("rst_ready1", 32'(tgt_ready[1]), 32'(1));

    // table-driven mapping vectors
    for (int v = 0; v < 10; v++) begin
      stuck[tbl[v].d] = tbl[v].stk;
      run_seq(tbl[v].d, tbl[v].tgt, tbl[v].ej, tbl[v].ek, tbl[v].em, 1'b0);
    end

    // saturation with bit 0 stuck at 0
    stuck[0] = 4'b0001;
    for (int r = 0; r < 300; r++) begin
      e  = excite(bank_q[0], 4'b0001, 1'b0);
      em = ((4'b0001 & ~stuck[0]) != 4'b0001);
      run_seq(0, 4'b0001, e[7:4], e[3:0], em, 1'b0);
    end
    chk("err_saturated", 32'(err_count[0]), 32'(255));

    // clear coinciding with a mismatch, then count again
    run_seq(0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    run_seq(0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0);

    // reset during DRIVE abandons the sequence
    stuck[0] = 4'b0000;
    e = excite(bank_q[0], 4'b0110, 1'b0);
    tgt_valid[0] = 1'b1;
    tgt_data[0]  = 4'b0110;
    @(negedge clk);
    tgt_valid[0] = 1'b0;
    chk("mid_jk_drive", 32'({j[0], k[0]}), 32'(e));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err[0] = 0;
    exp_err[1] = 0;
    chk("mid_busy", 32'(busy[0]), 32'(0));
    chk("mid_jk", 32'({j[0], k[0]}), 32'(0));
    chk("mid_ready", 32'(tgt_ready[0]), 32'(1));
    chk("mid_err", 32'(err_count[0]), 32'(0));
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_done", 32'({done[0], mismatch[0]}), 32'(0));
      @(negedge clk);
    end

    // continuous valid with new data every cycle
    ph = 0;
    done_exp = 1'b0;
    for (int c = 0; c < 30; c++) begin
      chk("hs_ready", 32'(tgt_ready[0]), 32'(ph == 0));
      chk("hs_busy", 32'(busy[0]), 32'(ph != 0));
      chk("hs_done", 32'(done[0]), 32'(done_exp));
      if (done_exp) chk("hs_mismatch", 32'(mismatch[0]), 32'(0));
      if (ph == 1) begin
        e = exp_q.pop_front();
        chk("hs_jk_drive", 32'({j[0], k[0]}), 32'(e));
      end
      if (ph == 2) chk("hs_jk_check", 32'({j[0], k[0]}), 32'(0));
      tgt_valid[0] = 1'b1;
      tgt_data[0]  = 4'($urandom_range(0, 15));
      if (ph == 0) exp_q.push_back(excite(bank_q[0], tgt_data[0], 1'b0));
      done_exp = (ph == 2);
      ph = (ph == 2) ? 0 : ph + 1;
      @(negedge clk);
    end
    tgt_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("hs_idle", 32'(busy[0]), 32'(0));
    chk("hs_err", 32'(err_count[0]), 32'(exp_err[0]));
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
